tail_light_decoder: RTL and testbench

Receive-side monitor for the six-lamp tail-light bus (`Lcba`, `Rabc`) driven by the tail-light sequencer. It samples the lamp pattern on each flasher step and decodes it back into a mode and step. It checks every step-to-step transition against the sequencer's legal transition set, flags illegal patterns and sequences, and detects a flashing sequence that has stopped advancing. It sits beside the sequencer for self-checking in the FPGA build and drives error LEDs and counters.

---
 rtl/tail_light_decoder.sv | 145 ++++++++++++++
 tb/tb_tail_light_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tail_light_decoder.sv
// rtl/tail_light_decoder.sv - tail-light bus monitor: decodes lamp patterns, flags illegal patterns/transitions and stalls
// Optional error counter built when TLD_ERR_COUNT_EN is defined.
module tail_light_decoder #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [2:0] Lcba,
    input  logic [2:0] Rabc,
    input  logic       err_clr,
    output logic [1:0] mode,
    output logic [1:0] step,
    output logic       valid,
    output logic       pat_err,
    output logic       seq_err,
    output logic       stuck,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HAZ
    } lamp_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    lamp_t      last, last_next, new_pat;
    logic       new_legal, trans_ok, flash_hold;
    logic [7:0] hold_cnt, hold_next;
    logic       valid_next, pat_err_next, seq_err_next, stuck_next;

    always_comb begin
        new_legal = 1'b1;
        new_pat   = S_OFF;
        case ({Lcba, Rabc})
            6'b000_000: new_pat = S_OFF;
            6'b001_000: new_pat = S_L1;
            6'b011_000: new_pat = S_L2;
            6'b111_000: new_pat = S_L3;
            6'b000_100: new_pat = S_R1;
            6'b000_110: new_pat = S_R2;
            6'b000_111: new_pat = S_R3;
            6'b111_111: new_pat = S_HAZ;
            default:    new_legal = 1'b0;
        endcase
    end

    // Restart patterns are reachable from anywhere; otherwise only hold or one step forward.
    always_comb begin
        trans_ok = (new_pat == last)
                || (new_pat == S_OFF) || (new_pat == S_HAZ)
                || (new_pat == S_L1)  || (new_pat == S_R1)
                || (last == S_L1 && new_pat == S_L2)
                || (last == S_L2 && new_pat == S_L3)
                || (last == S_R1 && new_pat == S_R2)
                || (last == S_R2 && new_pat == S_R3);
        flash_hold = (new_pat == last) && (last != S_OFF) && (last != S_HAZ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= S_OFF;
            hold_cnt <= 8'd0;
        end else begin
            last     <= last_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        last_next    = last;
        hold_next    = hold_cnt;
        valid_next   = 1'b0;
        pat_err_next = 1'b0;
        seq_err_next = 1'b0;
        stuck_next   = stuck;
        if (sample_en) begin
            if (new_legal) begin
                last_next    = new_pat;
                valid_next   = 1'b1;
                seq_err_next = !trans_ok;
                if (flash_hold)
                    hold_next = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                else
                    hold_next = 8'd0;
                if (flash_hold && hold_next >= HOLD_LIM)
                    stuck_next = 1'b1;
            end else begin
                pat_err_next = 1'b1;
            end
        end
        if (err_clr)
            stuck_next = 1'b0;
    end

    always_comb begin
        mode = 2'b00;
        step = 2'd0;
        case (last)
            S_L1:    begin mode = 2'b01; step = 2'd1; end
            S_L2:    begin mode = 2'b01; step = 2'd2; end
            S_L3:    begin mode = 2'b01; step = 2'd3; end
            S_R1:    begin mode = 2'b10; step = 2'd1; end
            S_R2:    begin mode = 2'b10; step = 2'd2; end
            S_R3:    begin mode = 2'b10; step = 2'd3; end
            S_HAZ:   begin mode = 2'b11; step = 2'd0; end
            default: begin mode = 2'b00; step = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            pat_err <= 1'b0;
            seq_err <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            valid   <= valid_next;
            pat_err <= pat_err_next;
            seq_err <= seq_err_next;
            stuck   <= stuck_next;
        end
    end

`ifdef TLD_ERR_COUNT_EN
    logic [7:0] err_cnt_q;
    logic       err_evt;

    assign err_evt = pat_err_next | seq_err_next;

    always_ff @(posedge clk) begin
        if (reset)
            err_cnt_q <= 8'd0;
        else if (err_clr)
            err_cnt_q <= err_evt ? 8'd1 : 8'd0;
        else if (err_evt && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tail_light_decoder.sv
// tb/tb_tail_light_decoder.sv - directed self-checking bench for tail_light_decoder
module tb_tail_light_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic [2:0] Lcba = 3'b000;
    logic [2:0] Rabc = 3'b000;
    logic       err_clr = 1'b0;
    logic [1:0] mode, step;
    logic       valid, pat_err, seq_err, stuck;
    logic [7:0] err_count;

`ifdef TLD_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [5:0] P_OFF = 6'b000_000, P_L1 = 6'b001_000, P_L2 = 6'b011_000,
                           P_L3 = 6'b111_000, P_R1 = 6'b000_100, P_R2 = 6'b000_110,
                           P_R3 = 6'b000_111, P_HAZ = 6'b111_111, P_BAD = 6'b001_001;

    int n_cmp = 0;
    int n_bad = 0;

    tail_light_decoder #(.HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .Lcba(Lcba), .Rabc(Rabc),
        .err_clr(err_clr), .mode(mode), .step(step), .valid(valid), .pat_err(pat_err),
        .seq_err(seq_err), .stuck(stuck), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // Called at a negedge; presents one sample across the next posedge and returns at the following negedge.
    task automatic smp(input logic [5:0] p, input logic clr);
        {Lcba, Rabc} = p;
        sample_en = 1'b1;
        err_clr = clr;
        @(negedge clk);
        sample_en = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err, stuck, err_count} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got mode=%b step=%0d v=%b pe=%b se=%b stuck=%b cnt=%0d want all zero",
                     mode, step, valid, pat_err, seq_err, stuck, err_count);
        end
    endtask

    task automatic test_left();
        logic [5:0] pats [4] = '{P_L1, P_L2, P_L3, P_L1};
        logic [6:0] exp  [4] = '{7'b01_01_100, 7'b01_10_100, 7'b01_11_100, 7'b01_01_100};
        for (int i = 0; i < 4; i++) begin
            smp(pats[i], 1'b0);
            n_cmp++;
            if ({mode, step, valid, pat_err, seq_err} !== exp[i]) begin
                n_bad++;
                $display("FAIL left_seq[%0d]: got %b want %b", i, {mode, step, valid, pat_err, seq_err}, exp[i]);
            end
        end
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL left_err_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_mixed();
        logic [5:0] pats [6] = '{P_OFF, P_R1, P_R2, P_L1, P_HAZ, P_OFF};
        logic [6:0] exp  [6] = '{7'b00_00_100, 7'b10_01_100, 7'b10_10_100,
                                 7'b01_01_100, 7'b11_00_100, 7'b00_00_100};
        for (int i = 0; i < 6; i++) begin
            smp(pats[i], 1'b0);
            n_cmp++;
            if ({mode, step, valid, pat_err, seq_err} !== exp[i]) begin
                n_bad++;
                $display("FAIL mixed_seq[%0d]: got %b want %b", i, {mode, step, valid, pat_err, seq_err}, exp[i]);
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        smp(6'b010_000, 1'b0);
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err} !== 7'b00_00_010) begin
            n_bad++;
            $display("FAIL pat_err_pulse: got %b want 0000010", {mode, step, valid, pat_err, seq_err});
        end
        smp(P_L2, 1'b0);
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err} !== 7'b01_10_101) begin
            n_bad++;
            $display("FAIL seq_err_pulse: got %b want 0110101", {mode, step, valid, pat_err, seq_err});
        end
        @(negedge clk);
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err} !== 7'b01_10_000) begin
            n_bad++;
            $display("FAIL idle_no_pulse: got %b want 0110000", {mode, step, valid, pat_err, seq_err});
        end
        n_cmp++;
        if (err_count !== (ERR_EN ? 8'd2 : 8'd0)) begin
            n_bad++;
            $display("FAIL err_count_two: got %0d want %0d", err_count, ERR_EN ? 2 : 0);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        smp(P_L1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            smp(P_L1, 1'b0);
            n_cmp++;
            if (stuck !== (i == 3)) begin
                n_bad++;
                $display("FAIL stuck_hold[%0d]: got %b want %b", i, stuck, (i == 3));
            end
        end
        smp(P_L1, 1'b1);
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_clr_with_stall: got %b want 0", stuck);
        end
        smp(P_L1, 1'b0);
        n_cmp++;
        if (stuck !== 1'b1) begin
            n_bad++;
            $display("FAIL stuck_reset_after_clr: got %b want 1", stuck);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            smp(P_HAZ, 1'b0);
            n_cmp++;
            if ({stuck, mode, valid} !== 4'b0_11_1) begin
                n_bad++;
                $display("FAIL haz_hold[%0d]: got stuck=%b mode=%b valid=%b want 0 11 1", i, stuck, mode, valid);
            end
        end
    endtask

    task automatic test_saturate();
        int bad_pe = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            smp(P_BAD, 1'b0);
            if (pat_err !== 1'b1 || valid !== 1'b0) bad_pe++;
        end
        n_cmp++;
        if (bad_pe != 0) begin
            n_bad++;
            $display("FAIL sat_pat_err: %0d samples lacked pat_err pulse, want 0", bad_pe);
        end
        n_cmp++;
        if (err_count !== (ERR_EN ? 8'd255 : 8'd0)) begin
            n_bad++;
            $display("FAIL err_count_sat: got %0d want %0d", err_count, ERR_EN ? 255 : 0);
        end
        smp(P_BAD, 1'b1);
        n_cmp++;
        if ({pat_err, err_count} !== {1'b1, (ERR_EN ? 8'd1 : 8'd0)}) begin
            n_bad++;
            $display("FAIL err_clr_with_err: got pe=%b cnt=%0d want pe=1 cnt=%0d", pat_err, err_count, ERR_EN ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back_reset();
        do_reset();
        smp(P_R1, 1'b0);
        smp(P_R2, 1'b0);
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err} !== 7'b10_10_100) begin
            n_bad++;
            $display("FAIL r2_before_reset: got %b want 1010100", {mode, step, valid, pat_err, seq_err});
        end
        do_reset();
        smp(P_R3, 1'b0);
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err} !== 7'b10_11_101) begin
            n_bad++;
            $display("FAIL r3_after_reset: got %b want 1011101", {mode, step, valid, pat_err, seq_err});
        end
        reset = 1'b1;
        smp(P_L1, 1'b1);
        reset = 1'b0;
        n_cmp++;
        if ({mode, step, valid, pat_err, seq_err, stuck, err_count} !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_with_sample: got mode=%b step=%0d v=%b pe=%b se=%b stuck=%b cnt=%0d want all zero",
                     mode, step, valid, pat_err, seq_err, stuck, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_mixed();
        test_errors();
        test_stuck();
        test_saturate();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
